// File: rtl/weight_bank_sequencer_pkg.sv
// Shared types and helpers for the weight bank sequencer: FSM state
// encoding, command mode codes and MAC enable-mask builders.
package wbs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAYER,
    SWAP,
    DONE
  } state_t;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_IDLE  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LAYER = 3'd2;

  // Widest MAC array the mask helpers can describe; callers truncate the
  // result to their own N_MACS with a size cast.
  localparam int MASK_W = 128;

  // Ones over the half-open MAC index range [lo, hi).
  function automatic logic [MASK_W-1:0] range_mask(input int lo, input int hi);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  // MACs owned by weight group g, each group being gsize MACs wide.
  function automatic logic [MASK_W-1:0] group_mask(input int g, input int gsize);
    return range_mask(g * gsize, (g + 1) * gsize);
  endfunction

  // MACs owned by half h (0 = low groups, 1 = high groups).
  function automatic logic [MASK_W-1:0] half_mask(input int h, input int n_groups,
                                                  input int gsize);
    int span;
    span = (n_groups / 2) * gsize;
    return range_mask(h * span, (h + 1) * span);
  endfunction

endpackage

// File: rtl/weight_bank_sequencer_if.sv
// Command, weight-stream handshake and MAC enable bundle for the weight
// bank sequencer. The master side issues commands and streams weights;
// the slave side is the sequencer itself.
interface weight_bank_sequencer_if
  import wbs_pkg::*;
#(
  parameter int N_MACS  = 8,
  parameter int LEN_W   = 16,
  parameter int LAYER_W = 8
) ();

  logic                start;
  logic [MODE_W-1:0]   mode;
  logic [LEN_W-1:0]    layer_len;
  logic [LAYER_W-1:0]  num_layers;
  logic                w_valid;
  logic                w_ready;
  logic [N_MACS-1:0]   weight_ctrl;
  logic [N_MACS-1:0]   compute_ctrl;
  logic                busy;
  logic                done;
  logic                err;
  logic                loaded;
  logic [15:0]         stall_cycles;

  modport master (
    output start, mode, layer_len, num_layers, w_valid,
    input  w_ready, weight_ctrl, compute_ctrl, busy, done, err, loaded,
           stall_cycles
  );

  modport slave (
    input  start, mode, layer_len, num_layers, w_valid,
    output w_ready, weight_ctrl, compute_ctrl, busy, done, err, loaded,
           stall_cycles
  );

endinterface

// File: rtl/weight_bank_sequencer_group_loader.sv
// Group/beat counter pair that walks a contiguous run of weight groups,
// DEPTH beats per group, under a valid/ready handshake. Used both for the
// full initial load and for the shadow-half load during layering.
module wbs_group_loader
  import wbs_pkg::*;
#(
  parameter  int N_GROUPS = 4,
  parameter  int DEPTH    = 16,
  localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int BW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          valid,
  input  logic [GW-1:0] first_group,
  input  logic [GW-1:0] last_offset,
  output logic          ready,
  output logic [GW-1:0] group,
  output logic          last_beat,
  output logic          complete
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(DEPTH - 1);

  logic [GW-1:0] group_off;
  logic [BW-1:0] beat;
  logic          done_q;
  logic          xfer;

  assign ready     = enable && !done_q;
  assign xfer      = valid && ready;
  assign group     = first_group + group_off;
  assign complete  = done_q;
  assign last_beat = xfer && (beat == BEAT_LAST) && (group_off == last_offset);

  // Advance the beat on each transfer; wrap into the next group, and latch
  // completion after the final beat of the final group.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      group_off <= '0;
      beat      <= '0;
      done_q    <= 1'b0;
    end else if (xfer) begin
      if (beat == BEAT_LAST) begin
        beat <= '0;
        if (group_off == last_offset) begin
          done_q <= 1'b1;
        end else begin
          group_off <= group_off + GW'(1);
        end
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_bank_sequencer.sv
// Weight bank sequencer: full group-by-group weight load, then
// double-buffered multi-layer operation where one half of the groups
// computes while the other half loads the next layer's weights.
// Optional build macro WBS_STALL_CNT_EN enables the layer-stall counter;
// without it stall_cycles is tied to zero.
module weight_bank_sequencer
  import wbs_pkg::*;
#(
  parameter int N_MACS   = 8,
  parameter int N_GROUPS = 4,
  parameter int DEPTH    = 16,
  parameter int LEN_W    = 16,
  parameter int LAYER_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  weight_bank_sequencer_if.slave bus
);

  localparam int G    = N_MACS / N_GROUPS;
  localparam int HALF = N_GROUPS / 2;
  localparam int GW   = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  state_t             state;
  state_t             state_next;
  logic               active_half;
  logic               loaded_q;
  logic               err_q;
  logic               comp_done;
  logic [LAYER_W-1:0] layers_left;
  logic [LEN_W-1:0]   len_m1;
  logic [LEN_W-1:0]   comp_cnt;

  logic [GW-1:0]      first_group;
  logic [GW-1:0]      last_offset;
  logic [GW-1:0]      cur_group;
  logic               ld_enable;
  logic               ld_clear;
  logic               ld_ready;
  logic               ld_last_beat;
  logic               ld_complete;

  logic               abort;
  logic               last_layer;
  logic               comp_last;
  logic               layer_finish;
  logic               accept_load;
  logic               accept_layer;

  assign abort        = (state != IDLE) && (bus.mode == MODE_IDLE);
  assign last_layer   = (layers_left == LAYER_W'(1));
  assign comp_last    = !comp_done && (comp_cnt == len_m1);
  assign layer_finish = (comp_done || comp_last) &&
                        (last_layer || ld_complete || ld_last_beat);
  assign accept_load  = (state == IDLE) && bus.start && (bus.mode == MODE_LOAD);
  assign accept_layer = (state == IDLE) && bus.start && (bus.mode == MODE_LAYER) &&
                        loaded_q && (bus.num_layers != '0);

  // Point the shared loader at all groups during LOAD, or at the shadow
  // half during a non-final layer; it is held cleared in every other state.
  always_comb begin
    ld_enable   = 1'b0;
    ld_clear    = 1'b1;
    first_group = '0;
    last_offset = GW'(N_GROUPS - 1);
    if (state == LOAD) begin
      ld_enable = 1'b1;
      ld_clear  = 1'b0;
    end else if (state == LAYER) begin
      ld_enable   = !last_layer;
      ld_clear    = 1'b0;
      first_group = active_half ? '0 : GW'(HALF);
      last_offset = GW'(HALF - 1);
    end
  end

  wbs_group_loader #(
    .N_GROUPS (N_GROUPS),
    .DEPTH    (DEPTH)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .clear       (ld_clear),
    .enable      (ld_enable),
    .valid       (bus.w_valid),
    .first_group (first_group),
    .last_offset (last_offset),
    .ready       (ld_ready),
    .group       (cur_group),
    .last_beat   (ld_last_beat),
    .complete    (ld_complete)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; an abort always wins over a completion in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_load) begin
          state_next = LOAD;
        end else if (accept_layer) begin
          state_next = LAYER;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (ld_last_beat) begin
          state_next = DONE;
        end
      end
      LAYER: begin
        if (abort) begin
          state_next = IDLE;
        end else if (layer_finish) begin
          state_next = last_layer ? DONE : SWAP;
        end
      end
      SWAP: begin
        state_next = abort ? IDLE : LAYER;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command capture, compute counter, half swapping and the loaded flag.
  // A fresh full load restarts layering from the low half.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_half <= 1'b0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
      comp_done   <= 1'b0;
      layers_left <= '0;
      len_m1      <= '0;
      comp_cnt    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_load) begin
            loaded_q    <= 1'b0;
            active_half <= 1'b0;
          end else if (accept_layer) begin
            layers_left <= bus.num_layers;
            len_m1      <= (bus.layer_len == '0) ? '0 : bus.layer_len - LEN_W'(1);
            comp_cnt    <= '0;
            comp_done   <= 1'b0;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_last_beat) begin
            loaded_q <= 1'b1;
          end
        end
        LAYER: begin
          if (comp_last) begin
            comp_done <= 1'b1;
          end else if (!comp_done) begin
            comp_cnt <= comp_cnt + LEN_W'(1);
          end
          if (layer_finish && last_layer) begin
            loaded_q <= 1'b0;
          end
        end
        SWAP: begin
          active_half <= ~active_half;
          layers_left <= layers_left - LAYER_W'(1);
          comp_cnt    <= '0;
          comp_done   <= 1'b0;
        end
        default: begin
        end
      endcase
      if (abort) begin
        loaded_q <= 1'b0;
      end
    end
  end

  // Moore output decode of the MAC enable masks.
  always_comb begin
    bus.weight_ctrl  = '0;
    bus.compute_ctrl = '0;
    if (ld_ready) begin
      bus.weight_ctrl = N_MACS'(group_mask(int'(cur_group), G));
    end
    if ((state == LAYER) && !comp_done) begin
      bus.compute_ctrl = N_MACS'(half_mask(int'(active_half), N_GROUPS, G));
    end
  end

  assign bus.w_ready = ld_ready;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.err     = err_q;
  assign bus.loaded  = loaded_q;

`ifdef WBS_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count LAYER cycles spent waiting on the shadow load after compute ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept_load || accept_layer) begin
      stall_cnt <= '0;
    end else if ((state == LAYER) && comp_done && !last_layer && !ld_complete &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: doc/weight_bank_sequencer.md
Name: weight_bank_sequencer

Overview:
Parametrised successor to the two-half weight pipeline controller. It splits N_MACS into N_GROUPS weight groups and sequences a full initial weight load group-by-group with a valid/ready handshake. It then runs multi-layer double-buffered operation: one half of the groups computes while the shadow half loads the next layer's weights, and the halves swap per layer. It sits between the weight streamer and the MAC array enables.

Parameters:
N_MACS, 8, total MAC count; must be a multiple of N_GROUPS.
N_GROUPS, 4, weight groups; even, ≥2; group g owns MACs [g*G +: G], G = N_MACS/N_GROUPS.
DEPTH, 16, weight beats per group.
LEN_W, 16, width of the per-layer compute length.
LAYER_W, 8, width of the layer count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle command strobe; sampled only in IDLE
mode  in  3  0 = idle/abort (any time); 1 = load all; 2 = layering; other = illegal
layer_len  in  LEN_W  compute cycles per layer; sampled at start; 0 treated as 1
num_layers  in  LAYER_W  layers to run; sampled at start
w_valid  in  1  weight beat available
w_ready  out  1  block accepts a beat; a beat transfers when w_valid && w_ready
weight_ctrl  out  N_MACS  weight-load enable mask for the group being loaded
compute_ctrl  out  N_MACS  compute enable mask for the active half
busy  out  1  state ≠ IDLE
done  out  1  one-cycle pulse on command completion
err  out  1  one-cycle pulse on a rejected command
loaded  out  1  full weight set present
stall_cycles  out  16  layer-stall counter (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; active_half = 0.
- States:
  - IDLE, LOAD, LAYER, SWAP, DONE.
  - Outputs are Moore, decoded from state and counters.
  - start at cycle t produces a new state visible at t+1.
- IDLE:
  - start && mode==1 → LOAD; group and beat counters cleared; loaded cleared.
  - start && mode==2 && loaded && num_layers≠0 → LAYER; compute counter cleared.
  - start with any other mode, or mode 2 without loaded, or num_layers==0 → err pulse; stay IDLE.
- LOAD:
  - w_ready = 1; weight_ctrl = mask of current group; compute_ctrl = 0.
  - Beat counter increments per transfer; at DEPTH-1 it wraps and the group advances.
  - Transfer of the last beat of group N_GROUPS-1 → DONE; loaded is set.
- LAYER:
  - compute_ctrl = active-half mask (active_half 0 → groups 0..N_GROUPS/2-1).
  - The compute counter runs layer_len cycles; after that compute_ctrl = 0 until the swap.
  - The shadow half loads in parallel, one group at a time, DEPTH beats each, with weight_ctrl = current shadow group mask.
  - Once the shadow load completes, w_ready = 0 and weight_ctrl = 0.
  - Last layer (layers_left==1): no shadow load; w_ready = 0 and weight_ctrl = 0 throughout.
  - Compute done && (shadow loaded || last layer):
    - if last layer → DONE, loaded cleared;
    - otherwise → SWAP.
- SWAP (1 cycle): all masks 0; active_half toggles; layers_left decrements; counters cleared; → LAYER.
- DONE (1 cycle): done = 1, busy = 1; → IDLE.
- Abort: mode==0 in any non-IDLE state → IDLE next cycle; loaded cleared; no done pulse. Abort overrides completion in the same cycle.
- start while busy is ignored.
- mode changes other than to 0 while busy are ignored.

Optional Feature:
WBS_STALL_CNT_EN. When defined, stall_cycles counts LAYER cycles where compute is done but the shadow load is incomplete. It saturates at 0xFFFF, is cleared on reset and on accepted start, and holds after DONE. When undefined, stall_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package wbs_pkg holds:
  - the state enum (IDLE/LOAD/LAYER/SWAP/DONE);
  - mode constants MODE_IDLE = 0, MODE_LOAD = 1, MODE_LAYER = 2;
  - the group-mask function group_mask(g) and half_mask(h).
- One natural sub-module: wbs_group_loader, the group/beat counter pair with handshake. It takes a first group, group count and enable, and outputs the current group, a last-beat strobe and a complete flag. It is shared by LOAD and the LAYER shadow load.

Test Plan:
All scenarios use N_MACS=8, N_GROUPS=4, DEPTH=4.
1. Reset, then idle: all outputs 0; busy = 0, loaded = 0.
2. start mode=1, w_valid=1 held: weight_ctrl = 0x03, 0x0C, 0x30, 0xC0 for 4 cycles each; done pulses in cycle 17; loaded = 1; busy = 0 in cycle 18.
3. After scenario 2, start mode=2, num_layers=2, layer_len=10, w_valid=1:
   - compute_ctrl = 0x0F for 10 cycles;
   - weight_ctrl = 0x30 ×4, then 0xC0 ×4, then 0;
   - one SWAP cycle with all masks 0;
   - compute_ctrl = 0xF0 for 10 cycles with weight_ctrl = 0 and w_ready = 0;
   - done pulses; loaded = 0.
4. Layering with layer_len=3 and w_valid=0 for 20 cycles, then 1:
   - compute_ctrl drops after 3 cycles; block holds in LAYER;
   - with WBS_STALL_CNT_EN, stall_cycles = 17 at release;
   - SWAP occurs 8 beats after release.
5. mode driven to 0 mid-LOAD (group 2): IDLE next cycle, masks 0, loaded = 0, no done; a following start mode=2 gives an err pulse with busy = 0.
6. start mode=5 in IDLE: err pulse for one cycle; state stays IDLE; start asserted during LOAD is ignored.
